// File: rtl/soc_system_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pio_pkg
//  Description : Shared register map constants for the HPS-facing PIO slaves
//                (word addresses, STATUS and CONTROL bit positions).
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_system_pio_pkg;

    // Word addresses of the command mailbox PIO
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_OUTPORT = 2'd3;

    // STATUS register bit positions
    localparam int PENDING   = 0;
    localparam int OVERRUN   = 1;
    localparam int COUNT_LSB = 16;

    // CONTROL register bit positions
    localparam int CLR_OVR = 0;
    localparam int ABORT   = 1;

endpackage : soc_system_pio_pkg
`default_nettype wire

// File: rtl/soc_system_mailbox_slot.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_mailbox_slot
//  Description : Single-entry valid/ready holding register. Loads a word when
//                empty or when the held word leaves in the same cycle, and
//                reports accepted / rejected / transferred strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_mailbox_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  abort,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  accepted,
    output logic                  rejected,
    output logic                  transferred
);

    // A transfer frees the slot in the same cycle, so a new word may replace it
    assign transferred = valid & ready;
    assign accepted    = load & (~valid | transferred);
    assign rejected    = load & valid & ~transferred;

    // Hold the word until it is transferred or aborted; a transfer beats an abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (accepted) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (transferred || abort) begin
            valid <= 1'b0;
        end
    end

endmodule : soc_system_mailbox_slot
`default_nettype wire

// File: rtl/soc_system_cmd_mailbox_pio.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_cmd_mailbox_pio
//  Description : Avalon-MM slave providing an HPS-to-fabric command mailbox
//                with transfer counting and sticky overrun, plus a plain
//                parallel output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_cmd_mailbox_pio
    import soc_system_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic        w_write;
    logic        w_load;
    logic        w_abort;
    logic        w_clr_ovr;
    logic        w_rejected;
    logic        w_transferred;
    logic        r_overrun;
    logic [15:0] r_xfer_count;
    logic [31:0] w_read_mux;

    assign w_write   = chipselect & ~write_n;
    assign w_load    = w_write && (address == ADDR_DATA);
    assign w_abort   = w_write && (address == ADDR_CONTROL) && writedata[ABORT];
    assign w_clr_ovr = w_write && (address == ADDR_CONTROL) && writedata[CLR_OVR];

    soc_system_mailbox_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .load        (w_load),
        .load_data   (writedata[DATA_WIDTH-1:0]),
        .abort       (w_abort),
        .ready       (cmd_ready),
        .data        (cmd_data),
        .valid       (cmd_valid),
        .accepted    (),
        .rejected    (w_rejected),
        .transferred (w_transferred)
    );

    // Sticky overrun (a new rejection beats a same-cycle clear) and wrapping transfer count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun    <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            if (w_rejected) begin
                r_overrun <= 1'b1;
            end else if (w_clr_ovr) begin
                r_overrun <= 1'b0;
            end
            if (w_transferred) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

    // Direct output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= OUT_RESET_VALUE;
        end else if (w_write && (address == ADDR_OUTPORT)) begin
            out_port <= writedata[DATA_WIDTH-1:0];
        end
    end

    // Read mux over pre-update state; unused upper bits read as zero
    always_comb begin
        w_read_mux = '0;
        case (address)
            ADDR_DATA: begin
                w_read_mux[DATA_WIDTH-1:0] = cmd_data;
            end
            ADDR_STATUS: begin
                w_read_mux[PENDING]        = cmd_valid;
                w_read_mux[OVERRUN]        = r_overrun;
                w_read_mux[31:COUNT_LSB]   = r_xfer_count;
            end
            ADDR_OUTPORT: begin
                w_read_mux[DATA_WIDTH-1:0] = out_port;
            end
            default: begin
                w_read_mux = '0;
            end
        endcase
    end

    // Registered read data, one cycle latency, no wait states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_read_mux;
        end
    end

endmodule : soc_system_cmd_mailbox_pio
`default_nettype wire
